// File: rtl/phased_array_pkg.sv
// Shared types and defaults for the phased-array square-wave driver.
package phased_array_pkg;

   // Default build: 8 channels, 11-bit timing fields, 40 kHz at 50 MHz.
   localparam int DEF_CHANNELS   = 8;
   localparam int DEF_CNT_W      = 11;
   localparam int DEF_PERIOD_RST = 1250;

   // Channel address width: ceil(log2(n)), never below 1.
   function automatic int addr_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w++;
      end
      return w;
   endfunction

   // Per-channel timing set. Field widths follow DEF_CNT_W, so a build
   // that overrides the driver's CNT_W must change DEF_CNT_W as well.
   typedef struct packed {
      logic [DEF_CNT_W-1:0] phase;
      logic [DEF_CNT_W-1:0] duty;
      logic                 chen;
   } chan_cfg_t;

endpackage

// File: rtl/phased_array_driver_channel.sv
// One output channel: shadow and active timing sets plus the registered
// compare that turns the shared period count into this channel's pulse.
module phase_channel
   import phased_array_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] period,
   input  logic             load,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_phase,
   input  logic [CNT_W-1:0] wr_duty,
   input  logic             wr_chen,
   output logic             q
);

   chan_cfg_t             shadow_cfg;
   chan_cfg_t             active_cfg;
   logic signed [CNT_W:0] diff;
   logic signed [CNT_W:0] rel;
   logic signed [CNT_W:0] duty_s;
   logic signed [CNT_W:0] period_s;

   // Host writes land in the shadow set only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_cfg <= '0;
      end else if (wr) begin
         shadow_cfg <= '{phase: wr_phase, duty: wr_duty, chen: wr_chen};
      end
   end

   // The active set changes only on the commit boundary, in step with every
   // other channel, so no output sees a half-updated configuration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_cfg <= '0;
      end else if (load) begin
         active_cfg <= shadow_cfg;
      end
   end

   // Position inside the pulse window: cnt - phase, folded back by one period
   // when the window started in the previous period. One extra bit of width
   // keeps the subtraction exact.
   always_comb begin
      period_s = $signed({1'b0, period});
      duty_s   = $signed({1'b0, active_cfg.duty});
      diff     = $signed({1'b0, cnt}) - $signed({1'b0, active_cfg.phase});
      rel      = (diff < 0) ? (diff + period_s) : diff;
   end

   // Registered channel level; duty 0 never matches, duty >= period always does.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= 1'b0;
      end else begin
         q <= active_cfg.chen & (rel < duty_s);
      end
   end

endmodule

// File: rtl/phased_array_driver.sv
// Multi-channel square-wave generator for the transducer array. A single
// period counter feeds every channel; host writes are staged in shadow
// registers and committed to all channels together at a period boundary.
module phased_array_driver
   import phased_array_pkg::*;
#(
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int PERIOD_RST = DEF_PERIOD_RST,
   parameter int ADDR_W     = addr_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                oe,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [CNT_W-1:0]    wr_phase,
   input  logic [CNT_W-1:0]    wr_duty,
   input  logic                wr_chen,
   input  logic                wr_period,
   input  logic                commit,
   output logic                busy,
   output logic                wr_err,
   output logic                sync,
   output logic [CHANNELS-1:0] out
);

   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    period_act;
   logic [CNT_W-1:0]    period_shd;
   logic                boundary;
   logic                load;
   logic [31:0]         addr_ext;
   logic                addr_bad;
   logic                phase_bad;
   logic                period_bad;
   logic                reject;
   logic                wr_ok;
   logic [CHANNELS-1:0] chan_wr;
   logic [CHANNELS-1:0] q;

   // Boundary detection and write validation. A phase is checked against the
   // shadow period because that is the period it will run with once committed.
   always_comb begin
      boundary   = (cnt == (period_act - CNT_W'(1)));
      load       = boundary & (busy | commit);
      addr_ext   = 32'(wr_addr);
      addr_bad   = (addr_ext >= 32'(CHANNELS));
      phase_bad  = ~wr_period & (wr_phase >= period_shd);
      period_bad = wr_period & (wr_duty < CNT_W'(2));
      reject     = addr_bad | phase_bad | period_bad;
      wr_ok      = wr_en & ~reject;
   end

   // Shared period counter; it restarts at 0 on every boundary, including the
   // commit boundary where the new period takes over.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (boundary) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Shadow period is written by period writes (value carried on wr_duty).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_shd <= CNT_W'(PERIOD_RST);
      end else if (wr_ok && wr_period) begin
         period_shd <= wr_duty;
      end
   end

   // Active period follows the shadow only at the commit boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_act <= CNT_W'(PERIOD_RST);
      end else if (load) begin
         period_act <= period_shd;
      end
   end

   // Commit handshake: a request is held until the next boundary serves it; a
   // request arriving in the boundary cycle is served at that same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
      end else if (load) begin
         busy <= 1'b0;
      end else if (commit) begin
         busy <= 1'b1;
      end
   end

   // Status pulses: rejected-write flag and period-start marker. sync lines up
   // with the channel outputs that were computed for cnt == 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err <= 1'b0;
         sync   <= 1'b0;
      end else begin
         wr_err <= wr_en & reject;
         sync   <= (cnt == '0);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign chan_wr[i] = wr_ok & ~wr_period & (addr_ext == 32'(i));

      phase_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .cnt      (cnt),
         .period   (period_act),
         .load     (load),
         .wr       (chan_wr[i]),
         .wr_phase (wr_phase),
         .wr_duty  (wr_duty),
         .wr_chen  (wr_chen),
         .q        (q[i])
      );
   end

   // Global enable gates the pins directly so it acts without a clock edge.
   assign out = q & {CHANNELS{oe}};

endmodule
